crg_seq_ctrl: RTL

Sequencer that configures the clock-reset generator's per-channel controls (source select, clock enable, reset request) on behalf of software or a CSR block.
- After global reset it brings channels up one at a time: ungate the clock, then release the reset.
- It then serves single-outstanding reconfiguration requests over a valid/ready port.
- Each switch runs a gate, switch, settle, ungate sequence, optionally wrapped in a channel reset, so no select change happens on a running clock.
- Runs on ref_clk_i.

---
 rtl/crg_seq_pkg.sv | 33 +++
 rtl/crg_seq_timer.sv | 33 +++
 rtl/crg_seq_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/crg_seq_pkg.sv
// rtl/crg_seq_pkg.sv - shared types and defaults for the CRG channel sequencer
package crg_seq_pkg;

  localparam int DEF_M          = 4;
  localparam int DEF_N          = 8;
  localparam int DEF_GATE_CYC   = 8;
  localparam int DEF_SETTLE_CYC = 8;
  localparam int DEF_RST_CYC    = 4;
  localparam int REQ_FIELD_W    = 8;

  typedef enum logic [2:0] {
    BOOT,
    IDLE,
    GATE,
    SETTLE,
    RST_HOLD
  } state_e;

  // Fields are sized for the largest supported configuration; the top slices them down.
  typedef struct packed {
    logic [REQ_FIELD_W-1:0] ch;
    logic [REQ_FIELD_W-1:0] sel;
    logic                   en;
    logic                   rst;
  } req_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/crg_seq_timer.sv
// rtl/crg_seq_timer.sv - loadable down-counter; expired_o is high while the count sits at zero
module crg_seq_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/crg_seq_ctrl.sv
// rtl/crg_seq_ctrl.sv - boots CRG channels one at a time, then runs gate/switch/settle/ungate
// reconfiguration sequences for single-outstanding requests.
module crg_seq_ctrl
  import crg_seq_pkg::*;
#(
  parameter int M          = DEF_M,
  parameter int N          = DEF_N,
  parameter int GATE_CYC   = DEF_GATE_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int RST_CYC    = DEF_RST_CYC
) (
  input  logic                          ref_clk_i,
  input  logic                          glob_arst_ni,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [$clog2(N)-1:0]          req_ch_i,
  input  logic [$clog2(M)-1:0]          req_sel_i,
  input  logic                          req_en_i,
  input  logic                          req_rst_i,
  output logic [N-1:0][$clog2(M)-1:0]   sel_o,
  output logic [N-1:0]                  en_o,
  output logic [N-1:0]                  arst_req_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o
);

  localparam int CH_W  = $clog2(N);
  localparam int SEL_W = $clog2(M);
  localparam int CNT_W = $clog2(max3(GATE_CYC, SETTLE_CYC, RST_CYC) + 1);

  state_e                  state_q, state_d;
  req_t                    req_q, req_d;
  logic [CH_W-1:0]         k_q, k_d;
  logic                    started_q, started_d;
  logic [N-1:0][SEL_W-1:0] sel_q, sel_d;
  logic [N-1:0]            en_q, en_d, arst_q, arst_d;
  logic                    ready_q, ready_d, busy_q, busy_d;
  logic                    done_q, done_d, err_q, err_d;
  logic                    tmr_load, tmr_expired;
  logic [CNT_W-1:0]        tmr_val;
  logic [CH_W-1:0]         ch;
  logic                    accept, req_ok;
  logic                    unused_req_bits;

  crg_seq_timer #(.WIDTH(CNT_W)) u_timer (
    .clk_i     (ref_clk_i),
    .rst_ni    (glob_arst_ni),
    .load_i    (tmr_load),
    .value_i   (tmr_val),
    .expired_o (tmr_expired)
  );

  assign ch              = req_q.ch[CH_W-1:0];
  assign accept          = req_valid_i && ready_q;
  assign req_ok          = (32'(req_ch_i) < N) && (32'(req_sel_i) < M);
  assign unused_req_bits = ^{req_q.ch, req_q.sel};

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    k_d       = k_q;
    started_d = started_q;
    sel_d     = sel_q;
    en_d      = en_q;
    arst_d    = arst_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state_q)
      BOOT: begin
        if (!started_q) begin
          started_d = 1'b1;
          en_d[0]   = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = CNT_W'(RST_CYC - 1);
        end else if (tmr_expired) begin
          arst_d[k_q] = 1'b0;
          if (32'(k_q) == N - 1) begin
            state_d = IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            k_d       = k_q + CH_W'(1);
            en_d[k_d] = 1'b1;
            tmr_load  = 1'b1;
            tmr_val   = CNT_W'(RST_CYC - 1);
          end
        end
      end
      IDLE: begin
        if (accept) begin
          if (!req_ok) begin
            err_d = 1'b1;
          end else if (req_sel_i == sel_q[req_ch_i] && !req_rst_i) begin
            // Source already selected: only the enable moves, no gating needed.
            en_d[req_ch_i] = req_en_i;
            done_d         = 1'b1;
          end else begin
            req_d.ch       = REQ_FIELD_W'(req_ch_i);
            req_d.sel      = REQ_FIELD_W'(req_sel_i);
            req_d.en       = req_en_i;
            req_d.rst      = req_rst_i;
            en_d[req_ch_i] = 1'b0;
            if (req_rst_i) arst_d[req_ch_i] = 1'b1;
            tmr_load       = 1'b1;
            tmr_val        = CNT_W'(GATE_CYC - 1);
            state_d        = GATE;
            ready_d        = 1'b0;
            busy_d         = 1'b1;
          end
        end
      end
      GATE: begin
        if (tmr_expired) begin
          sel_d[ch] = req_q.sel[SEL_W-1:0];
          tmr_load  = 1'b1;
          tmr_val   = CNT_W'(SETTLE_CYC - 1);
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        if (tmr_expired) begin
          en_d[ch] = req_q.en;
          if (req_q.rst) begin
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(RST_CYC - 1);
            state_d  = RST_HOLD;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      RST_HOLD: begin
        if (tmr_expired) begin
          arst_d[ch] = 1'b0;
          done_d     = 1'b1;
          state_d    = IDLE;
          ready_d    = 1'b1;
          busy_d     = 1'b0;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge ref_clk_i or negedge glob_arst_ni) begin
    if (!glob_arst_ni) begin
      state_q   <= BOOT;
      req_q     <= '0;
      k_q       <= '0;
      started_q <= 1'b0;
      sel_q     <= '0;
      en_q      <= '0;
      arst_q    <= '1;
      ready_q   <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      k_q       <= k_d;
      started_q <= started_d;
      sel_q     <= sel_d;
      en_q      <= en_d;
      arst_q    <= arst_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign sel_o       = sel_q;
  assign en_o        = en_q;
  assign arst_req_o  = arst_q;
  assign req_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
